// File: rtl/boot_sequencer.sv
// Boot sequencer: releases NUM_STAGES reset domains one at a time, each followed by an ack wait and a guard gap.
// Optional ack timeout is enabled by defining BOOT_SEQ_ACK_TIMEOUT_EN.
module boot_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned ACK_TIMEOUT = 256,
  localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  enable_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_no,
  output logic [IW-1:0]         stage_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  gap_exit;

`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] to_q, to_d;
  logic          error_q, error_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rst_n_d  = rst_n_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    done_d   = done_q;
    gap_exit = 1'b0;
`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
    to_d     = to_q;
    error_d  = error_q;
`endif
    if (!enable_i) begin
      // Abort: every domain goes back into reset together.
      state_d = S_IDLE;
      idx_d   = '0;
      rst_n_d = '0;
      gap_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
      to_d    = '0;
      error_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RELEASE;
        S_RELEASE: begin
          rst_n_d[idx_q] = 1'b1;
          busy_d         = 1'b1;
          state_d        = S_WAIT_ACK;
`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
          to_d           = '0;
`endif
        end
        S_WAIT_ACK: begin
          if (stage_ack_i[idx_q]) begin
            gap_d = '0;
            if (GAP_CYCLES == 0) gap_exit = 1'b1;
            else                 state_d  = S_GAP;
          end
`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            state_d = S_ERROR;
            rst_n_d = '0;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) gap_exit = 1'b1;
          else                   gap_d    = gap_q + 1'b1;
        end
        default: ;
      endcase

      if (gap_exit) begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          rst_n_d = '1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RELEASE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rst_n_q <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      to_q    <= '0;
      error_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign stage_rst_no = rst_n_q;
  assign stage_idx_o  = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: 4-stage/8-gap instance plus a 1-stage/0-gap instance.
module tb_boot_sequencer;

  logic       clk = 1'b0;
  logic       srst;
  logic       enable;
  logic [3:0] ack;
  logic [3:0] rst_n;
  logic [1:0] idx;
  logic       busy, done, error;

  logic [0:0] ack_s;
  logic [0:0] rst_n_s;
  logic [0:0] idx_s;
  logic       busy_s, done_s, error_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  boot_sequencer #(.NUM_STAGES(4), .GAP_CYCLES(8), .ACK_TIMEOUT(16)) u_dut (
    .clk_i(clk), .srst_i(srst), .enable_i(enable), .stage_ack_i(ack),
    .stage_rst_no(rst_n), .stage_idx_o(idx), .busy_o(busy), .done_o(done), .error_o(error)
  );

  boot_sequencer #(.NUM_STAGES(1), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_small (
    .clk_i(clk), .srst_i(srst), .enable_i(enable), .stage_ack_i(ack_s),
    .stage_rst_no(rst_n_s), .stage_idx_o(idx_s), .busy_o(busy_s), .done_o(done_s), .error_o(error_s)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected main-DUT outputs n edges after enable is sampled; d1 = extra cycles stage 1's ack is late.
  task automatic check_model(input int n, input int d1);
    int rel[4];
    int done_t;
    logic [3:0] e_rst;
    logic [1:0] e_idx;
    rel[0] = 1; rel[1] = 11; rel[2] = 21 + d1; rel[3] = 31 + d1;
    done_t = 40 + d1;
    e_rst = '0;
    for (int k = 0; k < 4; k++) if (n >= rel[k]) e_rst[k] = 1'b1;
    e_idx = 2'd0;
    for (int k = 1; k < 4; k++) if (n >= rel[k] - 1) e_idx = 2'(k);
    chk_val($sformatf("rst_n@%0d", n), 32'(rst_n), 32'(e_rst));
    chk_val($sformatf("idx@%0d", n),   32'(idx),   32'(e_idx));
    chk_val($sformatf("busy@%0d", n),  32'(busy),  32'((n >= 1 && n < done_t) ? 1 : 0));
    chk_val($sformatf("done@%0d", n),  32'(done),  32'((n >= done_t) ? 1 : 0));
  endtask

  task automatic start_seq();
    enable = 1'b0;
    step();
    chk_val("idle_rst_n", 32'(rst_n), 32'h0);
    chk_val("idle_busy",  32'(busy),  32'h0);
    chk_val("idle_done",  32'(done),  32'h0);
    enable = 1'b1;
  endtask

  initial begin
    srst = 1'b1; enable = 1'b0; ack = 4'hF; ack_s = 1'b1;
    step(); step();
    chk_val("rst_rst_n",   32'(rst_n),   32'h0);
    chk_val("rst_idx",     32'(idx),     32'h0);
    chk_val("rst_busy",    32'(busy),    32'h0);
    chk_val("rst_done",    32'(done),    32'h0);
    chk_val("rst_error",   32'(error),   32'h0);
    chk_val("rst_s_rst_n", 32'(rst_n_s), 32'h0);
    chk_val("rst_s_done",  32'(done_s),  32'h0);
    srst = 1'b0;

    // Nominal run on both instances.
    start_seq();
    for (int n = 0; n <= 42; n++) begin
      step();
      check_model(n, 0);
      chk_val($sformatf("s_rst_n@%0d", n), 32'(rst_n_s), 32'((n >= 1) ? 1 : 0));
      chk_val($sformatf("s_done@%0d", n),  32'(done_s),  32'((n >= 2) ? 1 : 0));
      chk_val($sformatf("s_busy@%0d", n),  32'(busy_s),  32'((n == 1) ? 1 : 0));
      chk_val($sformatf("s_idx@%0d", n),   32'(idx_s),   32'h0);
    end

    // Synchronous reset in DONE with enable held high, then rerun.
    srst = 1'b1;
    step();
    chk_val("srst_rst_n", 32'(rst_n), 32'h0);
    chk_val("srst_done",  32'(done),  32'h0);
    srst = 1'b0;
    for (int n = 0; n <= 41; n++) begin
      step();
      check_model(n, 0);
    end

    // Enable glitch during stage 2's guard gap restarts from stage 0.
    start_seq();
    for (int n = 0; n <= 25; n++) begin
      step();
      check_model(n, 0);
    end
    enable = 1'b0;
    step();
    chk_val("abort_rst_n", 32'(rst_n), 32'h0);
    chk_val("abort_idx",   32'(idx),   32'h0);
    chk_val("abort_busy",  32'(busy),  32'h0);
    enable = 1'b1;
    for (int n = 0; n <= 41; n++) begin
      step();
      check_model(n, 0);
    end

    // Stage 1 ack withheld 20 cycles.
    ack[1] = 1'b0;
    start_seq();
    for (int n = 0; n <= 61; n++) begin
      step();
      check_model(n, 20);
      if (n == 31) ack[1] = 1'b1;
    end

    // Stage 2 never acknowledges.
    ack[2] = 1'b0;
    start_seq();
    for (int n = 0; n <= 38; n++) begin
      step();
      if (n <= 21) check_model(n, 0);
      if (n == 36) begin
        chk_val("to_pre_error", 32'(error), 32'h0);
        chk_val("to_pre_rst_n", 32'(rst_n), 32'h7);
      end
`ifdef BOOT_SEQ_ACK_TIMEOUT_EN
      if (n >= 37) begin
        chk_val($sformatf("to_error@%0d", n), 32'(error), 32'h1);
        chk_val($sformatf("to_rst_n@%0d", n), 32'(rst_n), 32'h0);
        chk_val($sformatf("to_idx@%0d", n),   32'(idx),   32'h2);
        chk_val($sformatf("to_busy@%0d", n),  32'(busy),  32'h0);
      end
`else
      if (n == 38) begin
        chk_val("wait_error", 32'(error), 32'h0);
        chk_val("wait_rst_n", 32'(rst_n), 32'h7);
        chk_val("wait_busy",  32'(busy),  32'h1);
        chk_val("wait_idx",   32'(idx),   32'h2);
      end
`endif
    end
    enable = 1'b0;
    step();
    chk_val("clear_error", 32'(error), 32'h0);
    chk_val("clear_rst_n", 32'(rst_n), 32'h0);
    chk_val("clear_idx",   32'(idx),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Consumes the delayed enable produced by the power-up delay generator and releases a chain of downstream reset domains one at a time, in ascending index order.
- Each stage is released, its acknowledge is awaited, and a guard gap is counted before the next stage is released.
- Sits between the delay generator and the per-subsystem reset inputs (core, memories, peripherals, ...). Reports busy, done and error status to the SoC control registers.

Parameters:
- NUM_STAGES, 4, number of reset domains sequenced (>=1)
- GAP_CYCLES, 8, guard cycles after each acknowledge before the next release (0 = no gap)
- ACK_TIMEOUT, 256, max consecutive WAIT_ACK cycles without acknowledge before error (>=1); only used when the optional feature is enabled

Ports:
- clk_i  in  1  system clock
- srst_i  in  1  synchronous reset, active-high
- enable_i  in  1  sequence enable; delayed enable from the delay generator
- stage_ack_i  in  NUM_STAGES  per-stage "out of reset" acknowledge, level, synchronous to clk_i
- stage_rst_no  out  NUM_STAGES  per-stage reset, active-low, registered
- stage_idx_o  out  max(1,$clog2(NUM_STAGES))  index of the stage being processed
- busy_o  out  1  high in RELEASE/WAIT_ACK/GAP
- done_o  out  1  all stages released and guarded
- error_o  out  1  acknowledge timeout occurred

Behaviour:
- All outputs registered. Reset values: stage_rst_no=0 (all held in reset), stage_idx_o=0, busy_o=0, done_o=0, error_o=0; FSM=IDLE; counters=0.
- Priority per edge: srst_i > enable_i==0 > ack > timeout > gap count.
- States:
  - IDLE: enable_i=1 -> RELEASE.
  - RELEASE (1 cycle): stage_rst_no[idx] set to 1 -> WAIT_ACK; timeout counter cleared.
  - WAIT_ACK: stage_ack_i[idx]=1 -> GAP, gap counter cleared. If GAP_CYCLES==0, skip GAP and take the GAP exit action directly.
  - GAP: gap counter increments each cycle. On the cycle where it equals GAP_CYCLES-1:
    - idx==NUM_STAGES-1 -> DONE
    - otherwise idx+1 -> RELEASE
  - DONE: done_o=1, busy_o=0, all stage_rst_no=1; hold while enable_i=1.
  - ERROR: error_o=1, all stage_rst_no=0, stage_idx_o holds the failing index; hold while enable_i=1.
- Timing, with cycle n = n edges after the edge sampling enable_i=1 and acknowledges tied high:
  - stage k released (stage_rst_no[k] rises) at cycle 1+k*(GAP_CYCLES+2)
  - done_o rises at cycle NUM_STAGES*(GAP_CYCLES+2)
- Released stages stay released (bits set cumulatively) until abort, error or srst_i.
- enable_i low in any non-IDLE state: next edge sets all stage_rst_no=0, idx=0, counters=0, done_o=0, error_o=0, FSM=IDLE. All resets are re-asserted together, not in reverse order.
- A glitch or drop of enable_i mid-sequence restarts the sequence from stage 0 when enable_i returns.
- Acknowledge for stages other than idx is ignored. An acknowledge deasserting after being accepted is ignored.
- srst_i mid-sequence: identical to the reset values on the next edge.
- Counter widths are sized to hold GAP_CYCLES and ACK_TIMEOUT without wrap. Counters saturate and never wrap.

Optional Feature:
- Macro BOOT_SEQ_ACK_TIMEOUT_EN.
- Defined: WAIT_ACK counts consecutive cycles without acknowledge. When the count reaches ACK_TIMEOUT with stage_ack_i[idx] still low, the next state is ERROR. An acknowledge sampled on the same edge wins (-> GAP).
- Undefined: no timeout counter is built; WAIT_ACK waits indefinitely; error_o is tied to 0; ERROR is unreachable.

Test Plan:
- NUM_STAGES=4, GAP_CYCLES=8, acks tied high, enable_i rises -> stage_rst_no bits rise at cycles 1, 11, 21, 31; done_o=1 at cycle 40; busy_o high for cycles 1..39.
- stage_ack_i[1] withheld 20 cycles after its release, then asserted -> stage 2 released 20 cycles later than nominal; stage_idx_o=1 throughout the wait.
- With BOOT_SEQ_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, stage_ack_i[2] never asserted -> ERROR 16 cycles into WAIT_ACK: error_o=1, stage_rst_no=4'b0000, stage_idx_o=2. Dropping enable_i then clears error_o on the next edge.
- enable_i dropped for 1 cycle while in GAP of stage 2 -> next edge all stage_rst_no=0, IDLE; on re-enable the sequence restarts with stage 0 at cycle 1.
- srst_i pulsed in DONE -> next edge stage_rst_no=0, done_o=0; with enable_i held high the sequence reruns and done_o returns at cycle 40 after srst_i release.
- GAP_CYCLES=0, NUM_STAGES=1, ack high -> stage_rst_no[0] rises at cycle 1, done_o at cycle 2; stage_idx_o stays 0.
